// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF->ID pipeline stage.
package if_id_pkg;

    // Default datapath width of the fetch/decode fields.
    localparam int unsigned IF_ID_WIDTH = 32;

    // Canonical bubble instruction: addi x0, x0, 0.
    localparam logic [31:0] IF_ID_NOP_INST = 32'h0000_0013;

    // Occupancy of the stage: no entry, main entry only, main and skid entries.
    typedef enum logic [1:0] {EMPTY, FULL, SKID} if_id_state_e;

    // One fetched instruction with its PC fields, at the default width.
    typedef struct packed {
        logic [IF_ID_WIDTH-1:0] inst;
        logic [IF_ID_WIDTH-1:0] pc;
        logic [IF_ID_WIDTH-1:0] pcplus4;
    } if_id_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Enable-increment counter that sticks at all-ones; cleared only by reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: increment when enabled unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register, asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline register with a 2-entry skid buffer and synchronous flush.
// Optional perf counters enabled by defining IF_ID_PERF_CNT_EN.
module if_id_skid_stage
    import if_id_pkg::*;
#(
    parameter int unsigned     WIDTH    = IF_ID_WIDTH,
    parameter logic [WIDTH-1:0] NOP_INST = WIDTH'(IF_ID_NOP_INST),
    parameter int unsigned     CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             VALID_F,
    output logic             READY_F,
    input  logic [WIDTH-1:0] INST_F,
    input  logic [WIDTH-1:0] PC_F,
    input  logic [WIDTH-1:0] PCPLUS4_F,
    output logic             VALID_D,
    input  logic             READY_D,
    output logic [WIDTH-1:0] INST_D,
    output logic [WIDTH-1:0] PCD,
    output logic [WIDTH-1:0] PCPLUS4D,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] BUBBLE_CNT
);

    // Entry type at the instance width.
    typedef struct packed {
        logic [WIDTH-1:0] inst;
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] pcplus4;
    } entry_t;

    // Empty entries hold the bubble pattern so the outputs need no muxing.
    localparam entry_t BUBBLE = '{inst: NOP_INST, pc: '0, pcplus4: '0};

    if_id_state_e state_q, state_d;
    entry_t       main_q, main_d;
    entry_t       skid_q, skid_d;
    entry_t       fetch_entry;
    logic         accept;
    logic         deliver;

    assign fetch_entry = '{inst: INST_F, pc: PC_F, pcplus4: PCPLUS4_F};

    // Handshake decode straight from registered state.
    assign READY_F = (state_q != SKID);
    assign VALID_D = (state_q != EMPTY);
    assign accept  = VALID_F & READY_F;
    assign deliver = VALID_D & READY_D;

    // Next-state and entry movement; flush overrides every other event.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (FLUSH) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = fetch_entry;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (accept && deliver) begin
                        main_d = fetch_entry;
                    end else if (accept) begin
                        skid_d  = fetch_entry;
                        state_d = SKID;
                    end else if (deliver) begin
                        main_d  = BUBBLE;
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (deliver) begin
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    // State and entry registers, asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign INST_D   = main_q.inst;
    assign PCD      = main_q.pc;
    assign PCPLUS4D = main_q.pcplus4;

`ifdef IF_ID_PERF_CNT_EN
    logic stall_en;
    logic bubble_en;

    assign stall_en  = VALID_D & ~READY_D;
    assign bubble_en = ~VALID_D & READY_D;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .CLK (CLK),
        .RST (RST),
        .en  (stall_en),
        .cnt (STALL_CNT)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .CLK (CLK),
        .RST (RST),
        .en  (bubble_en),
        .cnt (BUBBLE_CNT)
    );
`else
    assign STALL_CNT  = '0;
    assign BUBBLE_CNT = '0;
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: directed table, async-reset and saturation
// sequences, and randomized traffic against a queue reference model.
module tb_if_id_skid_stage;

    localparam int unsigned WIDTH = 32;
`ifdef IF_ID_PERF_CNT_EN
    localparam int unsigned CNT_W = 4;
    localparam bit          PERF  = 1'b1;
`else
    localparam int unsigned CNT_W = 16;
    localparam bit          PERF  = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic             CLK = 1'b0;
    logic             RST;
    logic             FLUSH;
    logic             VALID_F;
    logic             READY_F;
    logic [WIDTH-1:0] INST_F;
    logic [WIDTH-1:0] PC_F;
    logic [WIDTH-1:0] PCPLUS4_F;
    logic             VALID_D;
    logic             READY_D;
    logic [WIDTH-1:0] INST_D;
    logic [WIDTH-1:0] PCD;
    logic [WIDTH-1:0] PCPLUS4D;
    logic [CNT_W-1:0] STALL_CNT;
    logic [CNT_W-1:0] BUBBLE_CNT;

    if_id_skid_stage #(
        .WIDTH    (WIDTH),
        .NOP_INST (NOP),
        .CNT_W    (CNT_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .FLUSH      (FLUSH),
        .VALID_F    (VALID_F),
        .READY_F    (READY_F),
        .INST_F     (INST_F),
        .PC_F       (PC_F),
        .PCPLUS4_F  (PCPLUS4_F),
        .VALID_D    (VALID_D),
        .READY_D    (READY_D),
        .INST_D     (INST_D),
        .PCD        (PCD),
        .PCPLUS4D   (PCPLUS4D),
        .STALL_CNT  (STALL_CNT),
        .BUBBLE_CNT (BUBBLE_CNT)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: in-order FIFO of at most two accepted PCs.
    logic [31:0] mq[$];
    int unsigned m_stall  = 0;
    int unsigned m_bubble = 0;
    int unsigned cnt_max  = (CNT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);

    // Instruction word tied to its PC so order/duplication is visible.
    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0003;
    endfunction

    // Drive one cycle of inputs (just after a falling edge), advance the model
    // across the coming rising edge, and return at the next falling edge.
    task automatic step(input logic vf, input logic rd, input logic fl, input logic [31:0] pc);
        bit m_valid;
        bit acc;
        bit dlv;
        VALID_F   = vf;
        READY_D   = rd;
        FLUSH     = fl;
        PC_F      = pc;
        INST_F    = mk_inst(pc);
        PCPLUS4_F = pc + 32'd4;
        m_valid = (mq.size() > 0);
        if (m_valid && !rd && m_stall < cnt_max) m_stall++;
        if (!m_valid && rd && m_bubble < cnt_max) m_bubble++;
        if (fl) begin
            mq.delete();
        end else begin
            acc = vf && (mq.size() < 2);
            dlv = m_valid && rd;
            if (dlv) void'(mq.pop_front());
            if (acc) mq.push_back(pc);
        end
        @(negedge CLK);
    endtask

    // Compare the decode-side outputs against an explicit expectation.
    task automatic check_exp(input string name, input logic ev, input logic [31:0] epc,
                             input logic erdy);
        logic [31:0] einst;
        logic [31:0] ep4;
        einst = ev ? mk_inst(epc) : NOP;
        ep4   = ev ? epc + 32'd4 : 32'd0;
        checks++;
        if (VALID_D !== ev || INST_D !== einst || PCD !== (ev ? epc : 32'd0) ||
            PCPLUS4D !== ep4 || READY_F !== erdy) begin
            failures++;
            $display("FAIL %s: got v=%b inst=%h pc=%h p4=%h rdy=%b, want v=%b inst=%h pc=%h p4=%h rdy=%b",
                     name, VALID_D, INST_D, PCD, PCPLUS4D, READY_F,
                     ev, einst, ev ? epc : 32'd0, ep4, erdy);
        end
    endtask

    // Compare outputs and counters against the reference model.
    task automatic check_model(input string name);
        logic [CNT_W-1:0] es;
        logic [CNT_W-1:0] eb;
        es = PERF ? CNT_W'(m_stall) : '0;
        eb = PERF ? CNT_W'(m_bubble) : '0;
        check_exp(name, mq.size() > 0, (mq.size() > 0) ? mq[0] : 32'd0, mq.size() < 2);
        checks++;
        if (STALL_CNT !== es || BUBBLE_CNT !== eb) begin
            failures++;
            $display("FAIL %s_cnt: got stall=%0d bubble=%0d, want stall=%0d bubble=%0d",
                     name, STALL_CNT, BUBBLE_CNT, es, eb);
        end
    endtask

    task automatic apply_reset();
        VALID_F = 1'b0;
        READY_D = 1'b0;
        FLUSH   = 1'b0;
        RST     = 1'b0;
        mq.delete();
        m_stall  = 0;
        m_bubble = 0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    typedef struct {
        logic        vf;
        logic        rd;
        logic        fl;
        logic [31:0] pc;
        logic        ev;
        logic [31:0] epc;
        logic        erdy;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // streaming
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h04, 1'b1, 32'h04, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h08, 1'b1, 32'h08, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1};
        // stall into skid, hold, drain
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h10, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h10, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h99, 1'b1, 32'h10, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h14, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1};
        // flush while in skid with fetch valid
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 32'h20, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h24, 1'b1, 32'h20, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b0, 32'h00, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1};

        INST_F    = '0;
        PC_F      = '0;
        PCPLUS4_F = '0;
        VALID_F   = 1'b0;
        READY_D   = 1'b0;
        FLUSH     = 1'b0;
        RST       = 1'b0;
        repeat (2) @(negedge CLK);
        check_model("reset");
        RST = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].vf, vecs[i].rd, vecs[i].fl, vecs[i].pc);
            check_exp($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].erdy);
        end
        check_model("post_table");

        // Asynchronous reset from SKID, observed before the next rising edge.
        step(1'b1, 1'b0, 1'b0, 32'h40);
        step(1'b1, 1'b0, 1'b0, 32'h44);
        check_model("pre_async_reset");
        #2 RST = 1'b0;
        #1 check_exp("async_reset", 1'b0, 32'd0, 1'b1);
        checks++;
        if (STALL_CNT !== '0 || BUBBLE_CNT !== '0) begin
            failures++;
            $display("FAIL async_reset_cnt: got stall=%0d bubble=%0d, want 0 0",
                     STALL_CNT, BUBBLE_CNT);
        end
        mq.delete();
        m_stall  = 0;
        m_bubble = 0;
        @(negedge CLK);
        RST = 1'b1;

        // Randomized traffic against the queue model.
        for (int c = 0; c < 10000; c++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) < 3,
                 $urandom_range(0, 31) == 0, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
            check_model("rand");
        end

        // Long stall to exercise counter saturation.
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 32'h100);
        for (int c = 0; c < 20; c++) step(1'b0, 1'b0, 1'b0, 32'd0);
        check_model("stall_hold");
        checks++;
        if (STALL_CNT !== (PERF ? CNT_W'((cnt_max < 20) ? cnt_max : 20) : CNT_W'(0))) begin
            failures++;
            $display("FAIL stall_sat: got stall=%0d, want %0d", STALL_CNT,
                     PERF ? ((cnt_max < 20) ? cnt_max : 20) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
